// File: rtl/mem_arbiter_pkg.sv
// Shared FSM encoding and requester-port indices for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and data-memory signals of the arbiter, seen from the arbiter (slave)
// or from the requesters plus memory (master).
interface mem_arbiter_if #(
  parameter int addresswidth = 32,
  parameter int width        = 32
);
  logic                    req0, req1;
  logic                    we0, we1;
  logic [addresswidth-1:0] addr0, addr1;
  logic [width-1:0]        wdata0, wdata1;
  logic                    ack0, ack1;
  logic                    err0, err1;
  logic [width-1:0]        rdata;
  logic [addresswidth-1:0] mem_address;
  logic                    mem_write_en, mem_read_en;
  logic [width-1:0]        mem_data_in;
  logic [width-1:0]        mem_data_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack0, ack1, err0, err1, rdata,
           mem_address, mem_write_en, mem_read_en, mem_data_in
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack0, ack1, err0, err1, rdata,
           mem_address, mem_write_en, mem_read_en, mem_data_in
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on contention the port not served last wins.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = PORT0;
    if (req == 2'b11) grant = ~last;
    else if (req[1])  grant = PORT1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one data memory; IDLE samples, ACCESS drives
// the memory for one cycle, RESP returns ack/err/rdata for one cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int addresswidth = 32,
  parameter int width        = 32,
  parameter int memaddrbits  = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  state_t                  r_state, w_next;
  logic                    r_sel, r_we, r_last;
  logic [addresswidth-1:0] r_addr;
  logic [width-1:0]        r_wdata, r_rdata;
  logic                    w_gnt, w_vld, w_err;

  rr_arbiter2 u_rr (
    .req   ({bus.req1, bus.req0}),
    .last  (r_last),
    .grant (w_gnt),
    .valid (w_vld)
  );

  // Misaligned or beyond the decoded window: the memory is never touched.
  assign w_err = (|r_addr[1:0]) | (|(r_addr >> memaddrbits));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_vld) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_address  = '0;
    bus.mem_data_in  = '0;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.ack0         = 1'b0;
    bus.ack1         = 1'b0;
    bus.err0         = 1'b0;
    bus.err1         = 1'b0;
    if (r_state == ACCESS) begin
      bus.mem_address  = r_addr;
      bus.mem_data_in  = r_wdata;
      bus.mem_read_en  = !r_we && !w_err;
      bus.mem_write_en =  r_we && !w_err;
    end
    if (r_state == RESP) begin
      bus.ack0 = (r_sel == PORT0);
      bus.ack1 = (r_sel == PORT1);
      bus.err0 = (r_sel == PORT0) && w_err;
      bus.err1 = (r_sel == PORT1) && w_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel   <= PORT0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_last  <= PORT1;
      r_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_vld) begin
        r_sel   <= w_gnt;
        r_last  <= w_gnt;
        r_we    <= (w_gnt == PORT1) ? bus.we1    : bus.we0;
        r_addr  <= (w_gnt == PORT1) ? bus.addr1  : bus.addr0;
        r_wdata <= (w_gnt == PORT1) ? bus.wdata1 : bus.wdata0;
      end
      // Memory data settles on the negedge inside ACCESS.
      if (r_state == ACCESS && !r_we && !w_err) r_rdata <= bus.mem_data_out;
    end
  end

  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed stimulus with a scoreboard queue; a negedge monitor pops on every ack.
module tb_mem_arbiter;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];
  logic [31:0] mem [0:1023];

  mem_arbiter_if #(.addresswidth(32), .width(32)) bus ();

  mem_arbiter #(.addresswidth(32), .width(32), .memaddrbits(12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory model: samples on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_write_en) mem[bus.mem_address[11:2]] = bus.mem_data_in;
    if (bus.mem_read_en)  bus.mem_data_out = mem[bus.mem_address[11:2]];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n && (bus.ack0 || bus.ack1)) begin
      chk("one_ack", 64'(bus.ack0 & bus.ack1), 0);
      chk("err_wo_ack", 64'((bus.err0 & ~bus.ack0) | (bus.err1 & ~bus.ack1)), 0);
      if (sbq.size() == 0) begin
        chk("unexp_ack", 64'({bus.ack1, bus.ack0}), 0);
      end else begin
        e = sbq.pop_front();
        chk("ack_port", 64'(bus.ack1), 64'(e.port));
        chk("ack_err", 64'(e.port ? bus.err1 : bus.err0), 64'(e.err));
        chk("rdata", 64'(bus.rdata), 64'(e.rdata));
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic acc(input bit p, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input bit e, input logic [31:0] rd);
    if (p) begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; end
    else   begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; end
    @(posedge clk); #1;
    sbq.push_back('{port: p, err: e, rdata: rd, cyc: cyc + 1});
    // Drop and scramble the request; the latched access must be unaffected.
    if (p) begin bus.req1 = 0; bus.addr1 = ~a; bus.wdata1 = ~wd; end
    else   begin bus.req0 = 0; bus.addr0 = ~a; bus.wdata0 = ~wd; end
    chk("acc_rd_en", 64'(bus.mem_read_en),  64'(!we && !e));
    chk("acc_wr_en", 64'(bus.mem_write_en), 64'(we && !e));
    chk("acc_addr", 64'(bus.mem_address), 64'(a));
    chk("acc_wdata", 64'(bus.mem_data_in), 64'(wd));
    @(posedge clk); #1;
    chk("resp_en", 64'({bus.mem_read_en, bus.mem_write_en}), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    reset_n = 0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    bus.mem_data_out = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    #3;
    chk("rst_ack", 64'({bus.ack1, bus.ack0}), 0);
    chk("rst_rdata", 64'(bus.rdata), 0);
    chk("rst_en", 64'({bus.mem_read_en, bus.mem_write_en}), 0);
    chk("rst_addr", 64'(bus.mem_address), 0);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;

    acc(0, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF);
    acc(1, 1, 32'h20, 32'h12345678, 0, 32'hDEADBEEF);
    chk("mem_wr", 64'(mem[8]), 64'h12345678);
    acc(1, 0, 32'h20, 32'h0,        0, 32'h12345678);
    acc(0, 0, 32'h1002, 32'h0,      1, 32'h12345678);
    acc(1, 0, 32'h00001001, 32'h0,  1, 32'h12345678);

    // Contention from reset: port 0 favoured, then strict alternation.
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_rdata", 64'(bus.rdata), 0);
    reset_n = 1;
    @(posedge clk); #1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h10;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h20;
    @(posedge clk); #1;
    n = cyc;
    sbq.push_back('{port: 0, err: 0, rdata: 32'hDEADBEEF, cyc: n + 1});
    sbq.push_back('{port: 1, err: 0, rdata: 32'h12345678, cyc: n + 4});
    sbq.push_back('{port: 0, err: 0, rdata: 32'hDEADBEEF, cyc: n + 7});
    sbq.push_back('{port: 1, err: 0, rdata: 32'h12345678, cyc: n + 10});
    repeat (9) @(posedge clk);
    #1;
    bus.req0 = 0; bus.req1 = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset lands mid-ACCESS: enables drop at once and no ack follows.
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h10;
    @(posedge clk); #1;
    bus.req0 = 0;
    chk("mid_rd_en", 64'(bus.mem_read_en), 1);
    reset_n = 0;
    #1;
    chk("arst_rd_en", 64'(bus.mem_read_en), 0);
    chk("arst_addr", 64'(bus.mem_address), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    @(posedge clk); #1;
    acc(0, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    chk("sb_drain", 64'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter addresswidth, default 32, meaning requester and memory address width.
REQ-002 SHALL have parameter width, default 32, meaning data word width.
REQ-003 SHALL have parameter memaddrbits, default 12, meaning number of low address bits decoded by the data memory.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req0 / req1  input  1  access request from port 0 (load/store) and port 1 (secondary master).
REQ-007 SHALL have port we0 / we1  input  1  1 = write, 0 = read.
REQ-008 SHALL have port addr0 / addr1  input  addresswidth  byte address.
REQ-009 SHALL have port wdata0 / wdata1  input  width  write data.
REQ-010 SHALL have port ack0 / ack1  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err0 / err1  output  1  valid with ack; access rejected.
REQ-012 SHALL have port rdata  output  width  read result, valid with ack of a read.
REQ-013 SHALL have port mem_address  output  addresswidth  to data memory.
REQ-014 SHALL have port mem_write_en / mem_read_en  output  1  to data memory.
REQ-015 SHALL have port mem_data_in  output  width  to data memory.
REQ-016 SHALL have port mem_data_out  input  width  from data memory; memory samples on negedge clk.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 IDLE: if any req, SHALL latch winner index, we, addr, wdata at posedge and go to ACCESS; else stay.
REQ-019 Arbitration SHALL be round-robin: both requesting -> port not served last wins; single requester always wins.
REQ-020 ACCESS (one cycle) SHALL drive mem_address/mem_data_in from latched values and assert exactly one of mem_read_en/mem_write_en; next state RESP.
REQ-021 RESP (one cycle) SHALL pulse ack of latched winner; for reads, rdata SHALL equal mem_data_out captured at the ACCESS->RESP posedge.
REQ-022 RESP SHALL return to IDLE; throughput one access per 3 cycles; request-to-ack latency 2 cycles after the sampling posedge.
REQ-023 Latched addr with addr[1:0] != 0 or any bit at or above memaddrbits set SHALL error: no mem enable asserted in ACCESS, err pulsed with ack, rdata unchanged.
REQ-024 rdata SHALL hold its last value after writes and errored accesses.
REQ-025 Outside ACCESS, mem_read_en and mem_write_en SHALL be 0 and mem_address/mem_data_in SHALL be 0.
REQ-026 Requests deasserted or changed after the IDLE sampling edge SHALL be ignored; the latched access completes.
REQ-027 ack0 and ack1 SHALL never be asserted in the same cycle; err only when the corresponding ack is 1.
REQ-028 Requester holding req after ack SHALL be treated as a new request in the following IDLE.

Reset
REQ-029 reset_n low SHALL immediately force IDLE, clear mem enables, ack/err, rdata=0, mem_address=0, mem_data_in=0, and set last-served to port 1 (port 0 favoured).
REQ-030 Reset mid-ACCESS SHALL drop the access without ack; after release, requests SHALL be re-arbitrated.

Structure
REQ-031 State encoding and port-index constants SHALL reside in shared package mem_arbiter_pkg.
REQ-032 Round-robin decision SHALL be a sub-module rr_arbiter2 (inputs req[1:0], last; output grant index, valid).

Verification
REQ-033 Single read: preload mem[0x10>>2]=0xDEADBEEF, req0 read addr 0x10 -> ack0 two cycles after sample, rdata=0xDEADBEEF, err0=0.
REQ-034 Write then read: port1 writes 0x12345678 to 0x20, then reads 0x20 -> mem_write_en one cycle, then rdata=0x12345678.
REQ-035 Contention: req0 and req1 held continuously after reset -> grants 0,1,0,1; never both acks in one cycle.
REQ-036 Errors: read addr 0x1002 and 0x00001001 -> ack with err=1, no mem enable, rdata unchanged.
REQ-037 Reset during ACCESS -> enables drop asynchronously, no ack; post-release request to 0x10 completes normally.
